// File: rtl/signed_divider_n.sv
// signed_divider_n: iterative restoring divider, one quotient bit per cycle, signed or unsigned.
// Optional build macro DIV_ZERO_DETECT_EN adds divide-by-zero detection. Rev 1.0
`default_nettype none

module signed_divider_n #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_ready,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_ovf,
    output logic             o_dbz
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
    logic             r_neg_d, r_neg_q, r_ovf_pend, r_dbz_pend;
    logic [WIDTH-1:0] r_q_out, r_r_out;
    logic             r_ovf, r_dbz;

    logic             w_accept, w_zero, w_sd, w_sv, w_ovf, w_ge;
    logic [WIDTH-1:0] w_mag_d, w_mag_v, w_diff, w_q_mag, w_r_mag, w_q_fin, w_r_fin;
    logic [WIDTH:0]   w_shift;

`ifdef DIV_ZERO_DETECT_EN
    assign w_zero = (i_divisor == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign o_ready     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign o_done      = (r_state == S_DONE);
    assign o_quotient  = r_q_out;
    assign o_remainder = r_r_out;
    assign o_ovf       = r_ovf;
    assign o_dbz       = r_dbz;
    assign w_accept    = i_start && o_ready;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign w_sd    = SIGNED && i_dividend[WIDTH-1];
    assign w_sv    = SIGNED && i_divisor[WIDTH-1];
    assign w_mag_d = w_sd ? (~i_dividend + C_ONE) : i_dividend;
    assign w_mag_v = w_sv ? (~i_divisor + C_ONE) : i_divisor;
    assign w_ovf   = SIGNED && (i_dividend == C_MIN) && (i_divisor == '1);

    // r_quo starts as the dividend and is replaced by quotient bits from the LSB end.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

    // On divide-by-zero the dividend magnitude is still parked in r_quo.
    assign w_q_mag = r_dbz_pend ? '1 : r_quo;
    assign w_r_mag = r_dbz_pend ? r_quo : r_rem;
    assign w_q_fin = (r_neg_q && !r_dbz_pend) ? (~w_q_mag + C_ONE) : w_q_mag;
    assign w_r_fin = r_neg_d ? (~w_r_mag + C_ONE) : w_r_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = w_zero ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == C_LAST) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: begin
                if (i_start) w_state_nxt = w_zero ? S_FIX : S_CALC;
                else         w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_neg_d    <= 1'b0;
            r_neg_q    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_q_out    <= '0;
            r_r_out    <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= w_mag_d;
            r_dvs      <= w_mag_v;
            r_neg_d    <= w_sd;
            r_neg_q    <= w_sd ^ w_sv;
            r_ovf_pend <= w_ovf;
            r_dbz_pend <= w_zero;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        end else if (r_state == S_FIX) begin
            r_q_out <= w_q_fin;
            r_r_out <= w_r_fin;
            r_ovf   <= r_ovf_pend;
            r_dbz   <= r_dbz_pend;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_signed_divider_n.sv
// tb_signed_divider_n: directed self-checking bench for signed_divider_n (signed and unsigned instances).
`default_nettype none

module tb_signed_divider_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        st0, st1;
    logic [15:0] dvd, dvs;
    logic        rdy0, done0, ovf0, dbz0, rdy1, done1, ovf1, dbz1;
    logic [15:0] q0, r0, q1, r1;
    int          checks = 0;
    int          errors = 0;
    int          got;

    always #5 clk = ~clk;

    signed_divider_n #(.WIDTH(16), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .i_start(st0), .i_dividend(dvd), .i_divisor(dvs),
        .o_ready(rdy0), .o_done(done0), .o_quotient(q0), .o_remainder(r0),
        .o_ovf(ovf0), .o_dbz(dbz0)
    );

    signed_divider_n #(.WIDTH(16), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst), .i_start(st1), .i_dividend(dvd), .i_divisor(dvs),
        .o_ready(rdy1), .o_done(done1), .o_quotient(q1), .o_remainder(r1),
        .o_ovf(ovf1), .o_dbz(dbz1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge (edge 0).
    task automatic launch(input bit sel, input logic [15:0] a, input logic [15:0] b);
        dvd = a;
        dvs = b;
        if (sel) st1 = 1'b1;
        else     st0 = 1'b1;
        @(posedge clk);
    endtask

    // Values seen at the negedge before edge k are the ones edge k samples.
    task automatic wait_done(input bit sel, input int inj_start, input int inj_rst, output int edge_no);
        edge_no = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            st0 = 1'b0;
            st1 = 1'b0;
            rst = 1'b0;
            if (k == inj_start) begin
                dvd = 16'd9;
                dvs = 16'd2;
                st0 = 1'b1;
            end
            if (k == inj_rst) rst = 1'b1;
            if (sel ? done1 : done0) begin
                edge_no = k;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; st0 = 1'b0; st1 = 1'b0; dvd = '0; dvs = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", {31'd0, rdy0}, 32'd1);
        chk("reset_done",  {31'd0, done0}, 32'd0);
        chk("reset_q",     {16'd0, q0}, 32'd0);
        chk("reset_r",     {16'd0, r0}, 32'd0);

        @(negedge clk);
        launch(0, 16'd100, 16'd7);
        wait_done(0, 0, 0, got);
        chk("p100_7_edge", got, 18);
        chk("p100_7_q", {16'd0, q0}, 32'd14);
        chk("p100_7_r", {16'd0, r0}, 32'd2);
        chk("p100_7_ovf", {31'd0, ovf0}, 32'd0);
        chk("p100_7_ready", {31'd0, rdy0}, 32'd1);
        @(negedge clk);
        chk("hold_done_low", {31'd0, done0}, 32'd0);
        chk("hold_q", {16'd0, q0}, 32'd14);

        launch(0, 16'hFF9C, 16'd7);
        wait_done(0, 0, 0, got);
        chk("m100_7_q", {16'd0, q0}, 32'h0000FFF2);
        chk("m100_7_r", {16'd0, r0}, 32'h0000FFFE);

        launch(0, 16'd100, 16'hFFF9);
        wait_done(0, 0, 0, got);
        chk("p100_m7_q", {16'd0, q0}, 32'h0000FFF2);
        chk("p100_m7_r", {16'd0, r0}, 32'h00000002);

        launch(0, 16'h8000, 16'hFFFF);
        wait_done(0, 0, 0, got);
        chk("min_m1_q", {16'd0, q0}, 32'h00008000);
        chk("min_m1_r", {16'd0, r0}, 32'd0);
        chk("min_m1_ovf", {31'd0, ovf0}, 32'd1);

        launch(0, 16'h8000, 16'd3);
        wait_done(0, 0, 0, got);
        chk("min_3_q", {16'd0, q0}, 32'h0000D556);
        chk("min_3_r", {16'd0, r0}, 32'h0000FFFE);
        chk("min_3_ovf", {31'd0, ovf0}, 32'd0);

        launch(0, 16'd100, 16'd7);
        wait_done(0, 5, 0, got);
        chk("ign_start_edge", got, 18);
        chk("ign_start_q", {16'd0, q0}, 32'd14);
        chk("ign_start_r", {16'd0, r0}, 32'd2);

        launch(0, 16'd100, 16'd7);
        wait_done(0, 0, 0, got);
        chk("b2b_first_q", {16'd0, q0}, 32'd14);
        launch(0, 16'd9, 16'd2);
        wait_done(0, 0, 0, got);
        chk("b2b_edge", got, 18);
        chk("b2b_q", {16'd0, q0}, 32'd4);
        chk("b2b_r", {16'd0, r0}, 32'd1);

        launch(0, 16'd100, 16'd7);
        wait_done(0, 0, 8, got);
        chk("abort_no_done", got, 0);
        chk("abort_q", {16'd0, q0}, 32'd0);
        chk("abort_r", {16'd0, r0}, 32'd0);
        chk("abort_ready", {31'd0, rdy0}, 32'd1);

        launch(0, 16'd50, 16'd5);
        wait_done(0, 0, 0, got);
        chk("p50_5_q", {16'd0, q0}, 32'd10);
        chk("p50_5_r", {16'd0, r0}, 32'd0);

        launch(0, 16'd5, 16'd0);
        wait_done(0, 0, 0, got);
`ifdef DIV_ZERO_DETECT_EN
        chk("dbz_edge", got, 2);
        chk("dbz_flag", {31'd0, dbz0}, 32'd1);
        chk("dbz_q", {16'd0, q0}, 32'h0000FFFF);
        chk("dbz_r", {16'd0, r0}, 32'd5);
        chk("dbz_ovf", {31'd0, ovf0}, 32'd0);
`else
        chk("dbz_edge", got, 18);
        chk("dbz_flag", {31'd0, dbz0}, 32'd0);
`endif

        launch(1, 16'hFFFF, 16'h0010);
        wait_done(1, 0, 0, got);
        chk("uns_edge", got, 18);
        chk("uns_q", {16'd0, q1}, 32'h00000FFF);
        chk("uns_r", {16'd0, r1}, 32'h0000000F);
        chk("uns_ovf", {31'd0, ovf1}, 32'd0);

        launch(1, 16'h8000, 16'hFFFF);
        wait_done(1, 0, 0, got);
        chk("uns_min_q", {16'd0, q1}, 32'd0);
        chk("uns_min_r", {16'd0, r1}, 32'h00008000);
        chk("uns_min_ovf", {31'd0, ovf1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/signed_divider_n.md
SIGNED_DIVIDER_N -- requirements
Module: signed_divider_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand, quotient and remainder width in bits, legal range 4..32.
REQ-002 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned operands.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_start, input, 1: request a division; sampled only while o_ready=1.
REQ-006 SHALL have port i_dividend, input, WIDTH: dividend, captured on the accepting edge.
REQ-007 SHALL have port i_divisor, input, WIDTH: divisor, captured on the accepting edge.
REQ-008 SHALL have port o_ready, output, 1: high in IDLE and DONE; a start may be accepted.
REQ-009 SHALL have port o_done, output, 1: one-cycle pulse, result valid.
REQ-010 SHALL have port o_quotient, output, WIDTH: quotient, held until the next accepted start.
REQ-011 SHALL have port o_remainder, output, WIDTH: remainder, held until the next accepted start.
REQ-012 SHALL have port o_ovf, output, 1: signed overflow flag, valid with o_done.
REQ-013 SHALL have port o_dbz, output, 1: divide-by-zero flag, valid with o_done.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE; IDLE->CALC on accepted start; CALC->FIX after WIDTH iterations; FIX->DONE; DONE->CALC on new start, else DONE->IDLE.
REQ-015 SHALL, on accept, store operand magnitudes (SIGNED=1) or raw values (SIGNED=0), plus the sign of dividend and the sign of quotient (dividend sign XOR divisor sign).
REQ-016 SHALL perform one restoring shift-subtract step per CALC cycle using a WIDTH+1-bit partial remainder; quotient bits shift in MSB first.
REQ-017 SHALL, in FIX, negate the quotient if the quotient sign is 1 and negate the remainder if the dividend sign is 1 (truncation toward zero; remainder takes the dividend sign).
REQ-018 SHALL assert o_done exactly WIDTH+2 rising edges after the edge that accepted i_start, for exactly one cycle.
REQ-019 SHALL ignore i_start while in CALC or FIX; the operands are not re-captured.
REQ-020 SHALL accept a start in the o_done cycle; the next result follows WIDTH+2 edges later.
REQ-021 SHALL, for SIGNED=1 with dividend = -2^(WIDTH-1) and divisor = -1, return quotient -2^(WIDTH-1), remainder 0, o_ovf=1; o_ovf=0 otherwise, including always when SIGNED=0.
REQ-022 SHALL update o_quotient, o_remainder, o_ovf and o_dbz only on the o_done cycle.
REQ-023 SHALL handle the magnitude of -2^(WIDTH-1) correctly as the unsigned value 2^(WIDTH-1).

Reset
REQ-024 SHALL, on rst=1 at a rising edge, enter IDLE and clear o_quotient, o_remainder, o_ovf, o_dbz and o_done to 0, with o_ready=1 on the following cycle.
REQ-025 SHALL abort an in-flight division on reset mid-operation, with no o_done pulse for it.
REQ-026 SHALL give rst priority over a simultaneous i_start.

Configuration
REQ-027 SHALL, with macro DIV_ZERO_DETECT_EN defined, handle a captured divisor of 0 by skipping CALC and going to DONE next edge (o_done 2 edges after accept), with o_dbz=1, o_quotient all ones, o_remainder = dividend, o_ovf=0.
REQ-028 SHALL, without DIV_ZERO_DETECT_EN, tie o_dbz to 0 and run divisor 0 through the normal WIDTH+2 path; the result is unspecified.

Verification (WIDTH=16, SIGNED=1 unless stated)
REQ-029 SHALL cover: 100/7 start -> o_done at edge 18, q=14, r=2, ovf=0; then -100/7 -> q=-14, r=-2; then 100/-7 -> q=-14, r=2.
REQ-030 SHALL cover: -32768/-1 -> q=-32768 (0x8000), r=0, o_ovf=1; then -32768/3 -> q=-10922, r=-2, o_ovf=0.
REQ-031 SHALL cover: with DIV_ZERO_DETECT_EN, 5/0 -> o_done at edge 2, o_dbz=1, q=0xFFFF, r=5; without the macro, o_dbz stays 0 and o_done comes at edge 18.
REQ-032 SHALL cover: a second i_start (9/2) at edge 5 of 100/7 is ignored -> q=14, r=2; a start held during o_done of 100/7 gives 9/2 -> q=4, r=1, 18 edges later.
REQ-033 SHALL cover: rst at edge 8 of 100/7 -> no o_done, outputs 0, o_ready=1; a new 50/5 start -> q=10, r=0.
REQ-034 SHALL cover: SIGNED=0, 0xFFFF/0x0010 -> q=0x0FFF, r=0x000F, o_ovf=0.
